// File: rtl/avst_host_cmd_arbiter.sv
// rtl/avst_host_cmd_arbiter.sv - round-robin sharing of one host cmd/rsp stream pair between two DMA requesters
// Reads record the issuing requester in a tag FIFO so in-order responses can be steered back.
module avst_host_cmd_arbiter #(
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 48,
  parameter int MAX_RD_OUTST = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [DATA_WIDTH+ADDR_WIDTH:0] req0_cmd_data,
  input  logic                           req0_cmd_valid,
  output logic                           req0_cmd_ready,
  output logic [DATA_WIDTH-1:0]          req0_rsp_data,
  output logic                           req0_rsp_valid,
  input  logic                           req0_rsp_ready,
  input  logic [DATA_WIDTH+ADDR_WIDTH:0] req1_cmd_data,
  input  logic                           req1_cmd_valid,
  output logic                           req1_cmd_ready,
  output logic [DATA_WIDTH-1:0]          req1_rsp_data,
  output logic                           req1_rsp_valid,
  input  logic                           req1_rsp_ready,
  output logic [DATA_WIDTH+ADDR_WIDTH:0] host_cmd_data,
  output logic                           host_cmd_valid,
  input  logic                           host_cmd_ready,
  input  logic [DATA_WIDTH-1:0]          host_rsp_data,
  input  logic                           host_rsp_valid,
  output logic                           host_rsp_ready,
  output logic [$clog2(MAX_RD_OUTST):0]  rd_outstanding,
  output logic                           err_unexp_rsp
);

  localparam int WR_BIT = DATA_WIDTH + ADDR_WIDTH;
  localparam int PTR_W  = $clog2(MAX_RD_OUTST);
  localparam int CNT_W  = PTR_W + 1;

  logic [DATA_WIDTH+ADDR_WIDTH:0] r_cmd_data;
  logic                           r_cmd_valid;
  logic                           r_last;
  logic                           r_tag_mem [MAX_RD_OUTST];
  logic [PTR_W-1:0]               r_wr_ptr;
  logic [PTR_W-1:0]               r_rd_ptr;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_err;

  logic w_slot_free;
  logic w_tag_full;
  logic w_tag_empty;
  logic w_elig0;
  logic w_elig1;
  logic w_grant0;
  logic w_grant1;
  logic w_push;
  logic w_pop;
  logic w_head;

  // Full is judged on the registered count, so a same-cycle pop never unblocks a read.
  assign w_tag_full  = (r_cnt == CNT_W'(MAX_RD_OUTST));
  assign w_tag_empty = (r_cnt == '0);
  assign w_slot_free = reset_n & (!r_cmd_valid | host_cmd_ready);
  assign w_elig0     = req0_cmd_valid & (req0_cmd_data[WR_BIT] | !w_tag_full);
  assign w_elig1     = req1_cmd_valid & (req1_cmd_data[WR_BIT] | !w_tag_full);

  // r_last holds the requester granted most recently; reset value 1 makes req0 preferred.
  assign w_grant0 = w_slot_free & w_elig0 & (!w_elig1 | r_last);
  assign w_grant1 = w_slot_free & w_elig1 & (!w_elig0 | !r_last);

  assign w_push = (w_grant0 & !req0_cmd_data[WR_BIT]) | (w_grant1 & !req1_cmd_data[WR_BIT]);
  assign w_head = r_tag_mem[r_rd_ptr];
  assign w_pop  = host_rsp_valid & host_rsp_ready;

  assign req0_cmd_ready = w_grant0;
  assign req1_cmd_ready = w_grant1;
  assign host_cmd_data  = r_cmd_data;
  assign host_cmd_valid = r_cmd_valid;
  assign rd_outstanding = r_cnt;
  assign err_unexp_rsp  = r_err;

  assign req0_rsp_data  = host_rsp_data;
  assign req1_rsp_data  = host_rsp_data;
  assign req0_rsp_valid = reset_n & !w_tag_empty & host_rsp_valid & !w_head;
  assign req1_rsp_valid = reset_n & !w_tag_empty & host_rsp_valid & w_head;
  assign host_rsp_ready = reset_n & !w_tag_empty & (w_head ? req1_rsp_ready : req0_rsp_ready);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cmd_data  <= '0;
      r_cmd_valid <= 1'b0;
      r_last      <= 1'b1;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_slot_free) begin
        r_cmd_valid <= w_grant0 | w_grant1;
        if (w_grant0 | w_grant1) begin
          r_cmd_data <= w_grant1 ? req1_cmd_data : req0_cmd_data;
        end
      end
      if (w_grant0 | w_grant1) begin
        r_last <= w_grant1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (host_rsp_valid & w_tag_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= w_grant1;
    end
  end

endmodule

// File: tb/tb_avst_host_cmd_arbiter.sv
// tb/tb_avst_host_cmd_arbiter.sv - directed self-checking bench for avst_host_cmd_arbiter
module tb_avst_host_cmd_arbiter;

  localparam int DW = 512;
  localparam int AW = 48;
  localparam int CW = DW + AW + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] req0_cmd_data, req1_cmd_data, host_cmd_data;
  logic          req0_cmd_valid, req0_cmd_ready, req1_cmd_valid, req1_cmd_ready;
  logic [DW-1:0] req0_rsp_data, req1_rsp_data, host_rsp_data;
  logic          req0_rsp_valid, req0_rsp_ready, req1_rsp_valid, req1_rsp_ready;
  logic          host_cmd_valid, host_cmd_ready, host_rsp_valid, host_rsp_ready;
  logic [6:0]    rd_outstanding;
  logic          err_unexp_rsp;

  int errors = 0;
  int checks = 0;
  int grants;
  logic [CW-1:0] w0, w1, wx, wy, rd0, rd1;
  logic [DW-1:0] exp_data [5];
  logic          exp_to1  [5];

  always #5 clk = ~clk;

  avst_host_cmd_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_cmd_data(req0_cmd_data), .req0_cmd_valid(req0_cmd_valid), .req0_cmd_ready(req0_cmd_ready),
    .req0_rsp_data(req0_rsp_data), .req0_rsp_valid(req0_rsp_valid), .req0_rsp_ready(req0_rsp_ready),
    .req1_cmd_data(req1_cmd_data), .req1_cmd_valid(req1_cmd_valid), .req1_cmd_ready(req1_cmd_ready),
    .req1_rsp_data(req1_rsp_data), .req1_rsp_valid(req1_rsp_valid), .req1_rsp_ready(req1_rsp_ready),
    .host_cmd_data(host_cmd_data), .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_rsp_data(host_rsp_data), .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
    .rd_outstanding(rd_outstanding), .err_unexp_rsp(err_unexp_rsp)
  );

  function automatic logic [CW-1:0] mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {wr, a, d};
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    w0  = mk(1'b1, 48'h100, 512'hA0);
    w1  = mk(1'b1, 48'h200, 512'hB0);
    wx  = mk(1'b1, 48'h300, 512'hC0);
    wy  = mk(1'b1, 48'h400, 512'hD0);
    rd0 = mk(1'b0, 48'h500, 512'h0);
    rd1 = mk(1'b0, 48'h600, 512'h0);
    reset_n = 1'b0;
    req0_cmd_data = w0; req0_cmd_valid = 1'b1; req0_rsp_ready = 1'b1;
    req1_cmd_data = w1; req1_cmd_valid = 1'b1; req1_rsp_ready = 1'b1;
    host_cmd_ready = 1'b1; host_rsp_valid = 1'b1; host_rsp_data = '0;

    // Reset held 3 cycles with every valid high
    repeat (3) begin
      cyc();
      chk("rst_rdy0", req0_cmd_ready, 0);
      chk("rst_rdy1", req1_cmd_ready, 0);
      chk("rst_hvalid", host_cmd_valid, 0);
      chk("rst_hrsprdy", host_rsp_ready, 0);
      chk("rst_rspv0", req0_rsp_valid, 0);
      chk("rst_outst", rd_outstanding, 0);
    end
    chk("rst_err", err_unexp_rsp, 0);
    host_rsp_valid = 1'b0;
    reset_n = 1'b1;

    // Writes from both requesters alternate starting with req0
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_rdy0", req0_cmd_ready, (k % 2 == 0));
      chk("rr_rdy1", req1_cmd_ready, (k % 2 == 1));
      cyc();
      chk("rr_hvalid", host_cmd_valid, 1);
      chk("rr_hdata", host_cmd_data, (k % 2 == 0) ? w0 : w1);
    end
    req0_cmd_valid = 1'b0; req1_cmd_valid = 1'b0;
    cyc();
    chk("rr_idle", host_cmd_valid, 0);

    // Interleaved reads R0,R1,R0,R1,R0
    req0_cmd_data = rd0; req1_cmd_data = rd1;
    req0_cmd_valid = 1'b1; req1_cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req1_cmd_valid = 1'b0;
      #1;
      chk("rd_rdy0", req0_cmd_ready, (k % 2 == 0));
      chk("rd_rdy1", req1_cmd_ready, (k % 2 == 1));
      cyc();
    end
    req0_cmd_valid = 1'b0;
    chk("rd_outst5", rd_outstanding, 5);
    chk("rd_hdata", host_cmd_data, rd0);
    for (int k = 0; k < 5; k++) begin
      exp_data[k] = DW'(10 + k);
      exp_to1[k]  = (k % 2 == 1);
    end
    host_rsp_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      host_rsp_data = exp_data[k];
      #1;
      chk("rsp_v0", req0_rsp_valid, !exp_to1[k]);
      chk("rsp_v1", req1_rsp_valid, exp_to1[k]);
      chk("rsp_data", exp_to1[k] ? req1_rsp_data : req0_rsp_data, exp_data[k]);
      chk("rsp_hrdy", host_rsp_ready, 1);
      cyc();
    end
    host_rsp_valid = 1'b0;
    chk("rsp_outst0", rd_outstanding, 0);
    chk("rsp_err", err_unexp_rsp, 0);

    // Response backpressure on req1
    req1_cmd_data = rd1; req1_cmd_valid = 1'b1;
    #1;
    chk("bp_rd1_rdy", req1_cmd_ready, 1);
    cyc();
    req1_cmd_valid = 1'b0;
    req1_rsp_ready = 1'b0; host_rsp_valid = 1'b1; host_rsp_data = DW'(32'h55);
    #1;
    chk("bp_hrsprdy0", host_rsp_ready, 0);
    chk("bp_rspv1", req1_rsp_valid, 1);
    chk("bp_rspv0", req0_rsp_valid, 0);
    cyc();
    chk("bp_held_data", req1_rsp_data, DW'(32'h55));
    chk("bp_outst1", rd_outstanding, 1);
    req1_rsp_ready = 1'b1;
    #1;
    chk("bp_hrsprdy1", host_rsp_ready, 1);
    cyc();
    host_rsp_valid = 1'b0;
    chk("bp_outst0", rd_outstanding, 0);

    // Command backpressure: output register holds while host stalls
    host_cmd_ready = 1'b0;
    req0_cmd_data = wx; req0_cmd_valid = 1'b1;
    #1;
    chk("cbp_rdy0", req0_cmd_ready, 1);
    cyc();
    req0_cmd_valid = 1'b0;
    req1_cmd_data = wy; req1_cmd_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cbp_rdy1", req1_cmd_ready, 0);
      chk("cbp_hvalid", host_cmd_valid, 1);
      chk("cbp_hdata", host_cmd_data, wx);
      cyc();
    end
    host_cmd_ready = 1'b1;
    #1;
    chk("cbp_release_rdy1", req1_cmd_ready, 1);
    cyc();
    req1_cmd_valid = 1'b0;
    chk("cbp_hdata_next", host_cmd_data, wy);
    cyc();

    // Fill the tag FIFO with 64 reads from req0
    req0_cmd_data = rd0; req0_cmd_valid = 1'b1;
    grants = 0;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (req0_cmd_ready) grants++;
      cyc();
    end
    chk("full_grants", grants, 64);
    chk("full_outst", rd_outstanding, 64);
    chk("full_rdy0", req0_cmd_ready, 0);
    req1_cmd_data = wy; req1_cmd_valid = 1'b1;
    #1;
    chk("full_wr_rdy1", req1_cmd_ready, 1);
    chk("full_rd_blocked", req0_cmd_ready, 0);
    cyc();
    req1_cmd_valid = 1'b0;
    host_rsp_valid = 1'b1; host_rsp_data = DW'(32'h77);
    #1;
    chk("full_pop_v0", req0_rsp_valid, 1);
    chk("full_pop_same_cycle", req0_cmd_ready, 0);
    cyc();
    host_rsp_valid = 1'b0;
    chk("full_outst63", rd_outstanding, 63);
    #1;
    chk("full_freed_rdy0", req0_cmd_ready, 1);
    cyc();
    chk("full_outst64b", rd_outstanding, 64);

    // Reset mid-traffic clears the FIFO and count
    reset_n = 1'b0;
    cyc();
    chk("mid_rst_outst", rd_outstanding, 0);
    chk("mid_rst_rdy0", req0_cmd_ready, 0);
    req0_cmd_valid = 1'b0;
    reset_n = 1'b1;
    #1;

    // Unexpected response with nothing outstanding
    host_rsp_valid = 1'b1; host_rsp_data = DW'(32'h99);
    #1;
    chk("unexp_hrsprdy", host_rsp_ready, 0);
    chk("unexp_rspv0", req0_rsp_valid, 0);
    chk("unexp_rspv1", req1_rsp_valid, 0);
    cyc();
    host_rsp_valid = 1'b0;
    chk("unexp_err_set", err_unexp_rsp, 1);
    repeat (3) cyc();
    chk("unexp_err_sticky", err_unexp_rsp, 1);

    // Fresh FIFO routes a new req1 read correctly
    req1_cmd_data = rd1; req1_cmd_valid = 1'b1;
    #1;
    chk("post_rd1_rdy", req1_cmd_ready, 1);
    cyc();
    req1_cmd_valid = 1'b0;
    chk("post_outst1", rd_outstanding, 1);
    host_rsp_valid = 1'b1; host_rsp_data = DW'(32'h3C);
    #1;
    chk("post_rspv1", req1_rsp_valid, 1);
    chk("post_rspv0", req0_rsp_valid, 0);
    cyc();
    host_rsp_valid = 1'b0;
    chk("post_outst0", rd_outstanding, 0);

    reset_n = 1'b0;
    cyc();
    chk("err_cleared", err_unexp_rsp, 0);
    reset_n = 1'b1;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
